// File: rtl/mac_lzc_pkg.sv
// Shared types and helpers for the grouped leading-zero/one counter.
package mac_lzc_pkg;

    typedef enum logic {
        LZC_ZEROS = 1'b0,
        LZC_ONES  = 1'b1
    } lzc_mode_e;

    function automatic int cnt_width(input int xlen);
        return $clog2(xlen + 1);
    endfunction

endpackage

// File: rtl/lzc_group.sv
// Combinational leading-zero count of one GROUP_W-bit group plus an all-zero flag.
module lzc_group #(
    parameter int GROUP_W = 8
) (
    input  logic [GROUP_W-1:0]         i_grp,
    output logic                       o_zero,
    output logic [$clog2(GROUP_W)-1:0] o_cnt
);

    localparam int LCW = $clog2(GROUP_W);

    assign o_zero = ~|i_grp;

    // NOTE: o_cnt gets a default before the loop so no path leaves it unassigned (no latch).
    always_comb begin
        o_cnt = '0;
        for (int i = 0; i < GROUP_W; i++) begin
            if (i_grp[i]) begin
                o_cnt = LCW'(GROUP_W - 1 - i);
            end
        end
    end

endmodule

// File: rtl/lzc_group_pipe.sv
// Two-stage leading-zero/one counter: stage 1 flags zero groups, stage 2 picks the first non-zero one.
module lzc_group_pipe
    import mac_lzc_pkg::*;
#(
    parameter  int XLEN    = 64,
    parameter  int GROUP_W = 8,
    parameter  int TAG_W   = 4,
    localparam int NGRP    = XLEN / GROUP_W,
    localparam int CNT_W   = cnt_width(XLEN),
    localparam int LCW     = $clog2(GROUP_W)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [XLEN-1:0]  data_i,
    input  logic             mode_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [CNT_W-1:0] count_o,
    output logic             all_o,
    output logic [TAG_W-1:0] tag_o
);

    logic             w_s1_ready;
    logic             w_s2_ready;
    logic [XLEN-1:0]  w_x;
    logic [NGRP-1:0]  w_gz;
    logic [LCW-1:0]   w_gcnt [NGRP];
    logic [CNT_W-1:0] w_count;
    logic             w_all;

    logic             r_s1_valid;
    logic [NGRP-1:0]  r_s1_gz;
    logic [LCW-1:0]   r_s1_gcnt [NGRP];
    logic [TAG_W-1:0] r_s1_tag;

    logic             r_s2_valid;
    logic [CNT_W-1:0] r_s2_count;
    logic             r_s2_all;
    logic [TAG_W-1:0] r_s2_tag;

    assign w_s2_ready = !r_s2_valid || ready_i;
    assign w_s1_ready = !r_s1_valid || w_s2_ready;
    assign ready_o    = w_s1_ready;

    // Counting leading ones is counting leading zeros of the inverted operand.
    assign w_x = (lzc_mode_e'(mode_i) == LZC_ONES) ? ~data_i : data_i;

    for (genvar g = 0; g < NGRP; g++) begin : g_grp
        lzc_group #(
            .GROUP_W (GROUP_W)
        ) u_grp (
            .i_grp  (w_x[XLEN-1-g*GROUP_W -: GROUP_W]),
            .o_zero (w_gz[g]),
            .o_cnt  (w_gcnt[g])
        );
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_s1_valid <= 1'b0;
        end else if (w_s1_ready) begin
            r_s1_valid <= valid_i;
        end
    end

    // NOTE: stage-1 payload is not reset; it is only ever observed behind r_s1_valid.
    always_ff @(posedge clk_i) begin
        if (valid_i && w_s1_ready) begin
            r_s1_gz   <= w_gz;
            r_s1_gcnt <= w_gcnt;
            r_s1_tag  <= tag_i;
        end
    end

    // Scanning from the least significant group upward leaves the most significant non-zero group selected.
    always_comb begin
        w_count = CNT_W'(XLEN);
        w_all   = 1'b1;
        for (int g = NGRP - 1; g >= 0; g--) begin
            if (!r_s1_gz[g]) begin
                w_count = CNT_W'(g * GROUP_W) + CNT_W'(r_s1_gcnt[g]);
                w_all   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_s2_valid <= 1'b0;
            r_s2_count <= '0;
            r_s2_all   <= 1'b0;
            r_s2_tag   <= '0;
        end else if (w_s2_ready) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_count <= w_count;
                r_s2_all   <= w_all;
                r_s2_tag   <= r_s1_tag;
            end
        end
    end

    assign valid_o = r_s2_valid;
    assign count_o = r_s2_count;
    assign all_o   = r_s2_all;
    assign tag_o   = r_s2_tag;

endmodule

// File: tb/tb_lzc_group_pipe.sv
// Self-checking bench: directed spec cases plus randomized traffic against a bit-scan reference model.
module tb_lzc_group_pipe;

    localparam int XLEN    = 64;
    localparam int GROUP_W = 8;
    localparam int TAG_W   = 4;
    localparam int CNT_W   = $clog2(XLEN + 1);

    logic             clk_i   = 1'b0;
    logic             rst_ni  = 1'b0;
    logic             valid_i = 1'b0;
    logic             mode_i  = 1'b0;
    logic             ready_i = 1'b1;
    logic [XLEN-1:0]  data_i  = '0;
    logic [TAG_W-1:0] tag_i   = '0;

    wire              ready_o, valid_o, all_o;
    wire  [CNT_W-1:0] count_o;
    wire  [TAG_W-1:0] tag_o;
    wire              ready_f, valid_f, all_f;
    wire  [CNT_W-1:0] count_f;
    wire  [TAG_W-1:0] tag_f;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [CNT_W-1:0] cnt;
        logic             all;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t q[$];

    lzc_group_pipe #(.XLEN(XLEN), .GROUP_W(GROUP_W), .TAG_W(TAG_W)) u_dut (
        .clk_i (clk_i), .rst_ni (rst_ni), .valid_i (valid_i), .ready_o (ready_o),
        .data_i (data_i), .mode_i (mode_i), .tag_i (tag_i), .valid_o (valid_o),
        .ready_i (ready_i), .count_o (count_o), .all_o (all_o), .tag_o (tag_o)
    );

    // Degenerate single-group configuration driven with the same stimulus.
    lzc_group_pipe #(.XLEN(XLEN), .GROUP_W(XLEN), .TAG_W(TAG_W)) u_dut_flat (
        .clk_i (clk_i), .rst_ni (rst_ni), .valid_i (valid_i), .ready_o (ready_f),
        .data_i (data_i), .mode_i (mode_i), .tag_i (tag_i), .valid_o (valid_f),
        .ready_i (ready_i), .count_o (count_f), .all_o (all_f), .tag_o (tag_f)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic exp_t model(input logic [XLEN-1:0] d, input logic m, input logic [TAG_W-1:0] t);
        exp_t e;
        int n;
        logic [XLEN-1:0] x;
        x = m ? ~d : d;
        n = 0;
        for (int i = XLEN - 1; i >= 0; i--) begin
            if (x[i]) break;
            n++;
        end
        e.cnt = CNT_W'(n);
        e.all = (n == XLEN);
        e.tag = t;
        return e;
    endfunction

    // One clock cycle: drive at the falling edge, observe before the next rising edge.
    task automatic step(input logic v, input logic [XLEN-1:0] d, input logic m,
                        input logic [TAG_W-1:0] t, input logic rdy,
                        output logic acc, output logic pop, output exp_t got, output exp_t got_f);
        @(negedge clk_i);
        valid_i = v; data_i = d; mode_i = m; tag_i = t; ready_i = rdy;
        #1;
        acc       = v && ready_o;
        pop       = valid_o && rdy;
        got.cnt   = count_o; got.all   = all_o; got.tag   = tag_o;
        got_f.cnt = count_f; got_f.all = all_f; got_f.tag = tag_f;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; valid_i = 1'b1; data_i = 64'h1234; tag_i = 4'hA; ready_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            #1;
            checks++;
            if (valid_o !== 1'b0 || count_o !== '0 || tag_o !== '0 || all_o !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold: valid=%0b count=%0d all=%0b tag=%0d expected 0 0 0 0",
                         valid_o, count_o, all_o, tag_o);
            end
        end
        @(negedge clk_i);
        rst_ni = 1'b1; valid_i = 1'b0;
        #1;
        checks++;
        if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: ready_o=%0b valid_o=%0b expected 1 0", ready_o, valid_o);
        end
    endtask

    task automatic run_one(input string name, input logic [XLEN-1:0] d, input logic m,
                           input logic [TAG_W-1:0] t, input int exp_cnt, input logic exp_all);
        logic acc, pop;
        exp_t got, gf;
        step(1'b1, d, m, t, 1'b1, acc, pop, got, gf);
        checks++;
        if (acc !== 1'b1) begin
            errors++;
            $display("FAIL %s_accept: ready_o=%0b expected 1", name, acc);
        end
        step(1'b0, '0, 1'b0, '0, 1'b1, acc, pop, got, gf);
        checks++;
        if (pop !== 1'b0) begin
            errors++;
            $display("FAIL %s_early: valid_o=%0b expected 0 after one cycle", name, pop);
        end
        step(1'b0, '0, 1'b0, '0, 1'b1, acc, pop, got, gf);
        checks++;
        if (pop !== 1'b1 || got.cnt !== CNT_W'(exp_cnt) || got.all !== exp_all || got.tag !== t) begin
            errors++;
            $display("FAIL %s: valid=%0b count=%0d all=%0b tag=%0d expected valid=1 count=%0d all=%0b tag=%0d",
                     name, pop, got.cnt, got.all, got.tag, exp_cnt, exp_all, t);
        end
        checks++;
        if (valid_f !== 1'b1 || gf.cnt !== CNT_W'(exp_cnt) || gf.all !== exp_all || gf.tag !== t) begin
            errors++;
            $display("FAIL %s_flat: valid=%0b count=%0d all=%0b tag=%0d expected valid=1 count=%0d all=%0b tag=%0d",
                     name, valid_f, gf.cnt, gf.all, gf.tag, exp_cnt, exp_all, t);
        end
    endtask

    task automatic test_basic_lzc();
        run_one("lzc_bit20", 64'h0000_0000_0010_0000, 1'b0, 4'd3, 43, 1'b0);
        run_one("lzc_msb",   64'h8000_0000_0000_0000, 1'b0, 4'd4, 0,  1'b0);
        run_one("lzc_lsb",   64'h0000_0000_0000_0001, 1'b0, 4'd5, 63, 1'b0);
        run_one("lzc_zero",  64'h0,                   1'b0, 4'd6, 64, 1'b1);
    endtask

    task automatic test_lo_mode();
        run_one("lo_12",   64'hFFF0_0000_0000_0000, 1'b1, 4'd7, 12, 1'b0);
        run_one("lo_ones", 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 4'd8, 64, 1'b1);
        run_one("lo_zero", 64'h0,                   1'b1, 4'd9, 0,  1'b0);
    endtask

    task automatic test_back_to_back();
        logic acc, pop;
        exp_t got, gf, e;
        int first, last, pops;
        logic [XLEN-1:0] d;
        first = -1; last = -1; pops = 0;
        q.delete();
        for (int c = 0; c < 14; c++) begin
            d = {$urandom(), $urandom()} >> $urandom_range(0, 64);
            step(c < 8, d, 1'b0, TAG_W'(c), 1'b1, acc, pop, got, gf);
            if (pop) begin
                e = q.pop_front();
                checks++;
                if (got.cnt !== e.cnt || got.all !== e.all || got.tag !== e.tag) begin
                    errors++;
                    $display("FAIL b2b_result: count=%0d all=%0b tag=%0d expected count=%0d all=%0b tag=%0d",
                             got.cnt, got.all, got.tag, e.cnt, e.all, e.tag);
                end
                if (first < 0) first = c;
                last = c;
                pops++;
            end
            if (acc) q.push_back(model(d, 1'b0, TAG_W'(c)));
        end
        valid_i = 1'b0;
        checks++;
        if (pops != 8 || last - first != 7 || first != 2) begin
            errors++;
            $display("FAIL b2b_timing: pops=%0d first=%0d last=%0d expected 8 results on cycles 2..9",
                     pops, first, last);
        end
    endtask

    task automatic test_backpressure();
        logic acc, pop;
        exp_t got, gf, e, held;
        logic [XLEN-1:0] ops [4];
        int idx, pops;
        idx = 0; pops = 0;
        q.delete();
        for (int i = 0; i < 4; i++) ops[i] = {$urandom(), $urandom()} >> $urandom_range(0, 64);
        for (int c = 0; c < 5; c++) begin
            step(1'b1, ops[idx], 1'b0, TAG_W'(4'hC + idx), 1'b0, acc, pop, got, gf);
            if (c >= 2) begin
                checks++;
                if (acc !== 1'b0 || valid_o !== 1'b1) begin
                    errors++;
                    $display("FAIL bp_stall: ready_o=%0b valid_o=%0b expected 0 1 with both stages full",
                             acc, valid_o);
                end
                if (c == 2) held = got;
                else begin
                    checks++;
                    if (got.cnt !== held.cnt || got.tag !== held.tag || got.all !== held.all) begin
                        errors++;
                        $display("FAIL bp_hold: count=%0d tag=%0d expected stable count=%0d tag=%0d",
                                 got.cnt, got.tag, held.cnt, held.tag);
                    end
                end
            end
            if (acc) begin
                q.push_back(model(ops[idx], 1'b0, TAG_W'(4'hC + idx)));
                idx++;
            end
        end
        for (int c = 0; c < 20 && (idx < 4 || q.size() > 0); c++) begin
            step(idx < 4, (idx < 4) ? ops[idx < 4 ? idx : 0] : '0, 1'b0, TAG_W'(4'hC + idx), 1'b1,
                 acc, pop, got, gf);
            if (pop) begin
                pops++;
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL bp_extra: unexpected result tag=%0d", got.tag);
                end else begin
                    e = q.pop_front();
                    if (got.cnt !== e.cnt || got.all !== e.all || got.tag !== e.tag) begin
                        errors++;
                        $display("FAIL bp_result: count=%0d tag=%0d expected count=%0d tag=%0d",
                                 got.cnt, got.tag, e.cnt, e.tag);
                    end
                end
            end
            if (acc && idx < 4) begin
                q.push_back(model(ops[idx], 1'b0, TAG_W'(4'hC + idx)));
                idx++;
            end
        end
        valid_i = 1'b0;
        checks++;
        if (pops != 4 || q.size() != 0) begin
            errors++;
            $display("FAIL bp_count: results=%0d pending=%0d expected 4 0", pops, q.size());
        end
    endtask

    task automatic test_reset_midflight();
        logic acc, pop;
        exp_t got, gf;
        step(1'b1, 64'h00FF, 1'b0, 4'd1, 1'b0, acc, pop, got, gf);
        step(1'b1, 64'h0F00, 1'b0, 4'd2, 1'b0, acc, pop, got, gf);
        @(negedge clk_i);
        rst_ni = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1; ready_i = 1'b1;
        #1;
        checks++;
        if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
            errors++;
            $display("FAIL midreset_flush: valid_o=%0b ready_o=%0b expected 0 1", valid_o, ready_o);
        end
        for (int c = 0; c < 3; c++) begin
            step(1'b0, '0, 1'b0, '0, 1'b1, acc, pop, got, gf);
            checks++;
            if (pop !== 1'b0) begin
                errors++;
                $display("FAIL midreset_ghost: result tag=%0d emitted after flush", got.tag);
            end
        end
        run_one("midreset_next", 64'h0000_0400_0000_0000, 1'b0, 4'd11, 21, 1'b0);
    endtask

    task automatic test_random();
        logic acc, pop, v, m, rdy;
        exp_t got, gf, e;
        logic [XLEN-1:0] d;
        logic [TAG_W-1:0] t;
        q.delete();
        for (int c = 0; c < 400; c++) begin
            v   = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 3) != 0);
            m   = 1'($urandom_range(0, 1));
            d   = {$urandom(), $urandom()} >> $urandom_range(0, 64);
            if (m) d = ~d;
            t   = TAG_W'($urandom());
            step(v, d, m, t, rdy, acc, pop, got, gf);
            if (pop) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL rand_extra: unexpected result tag=%0d", got.tag);
                end else begin
                    e = q.pop_front();
                    if (got.cnt !== e.cnt || got.all !== e.all || got.tag !== e.tag) begin
                        errors++;
                        $display("FAIL rand_result: count=%0d all=%0b tag=%0d expected count=%0d all=%0b tag=%0d",
                                 got.cnt, got.all, got.tag, e.cnt, e.all, e.tag);
                    end
                    checks++;
                    if (valid_f !== 1'b1 || gf.cnt !== e.cnt || gf.all !== e.all || gf.tag !== e.tag) begin
                        errors++;
                        $display("FAIL rand_flat: valid=%0b count=%0d all=%0b expected valid=1 count=%0d all=%0b",
                                 valid_f, gf.cnt, gf.all, e.cnt, e.all);
                    end
                end
            end
            if (acc) q.push_back(model(d, m, t));
        end
        for (int c = 0; c < 10 && q.size() > 0; c++) begin
            step(1'b0, '0, 1'b0, '0, 1'b1, acc, pop, got, gf);
            if (pop) begin
                e = q.pop_front();
                checks++;
                if (got.cnt !== e.cnt || got.all !== e.all || got.tag !== e.tag) begin
                    errors++;
                    $display("FAIL rand_drain: count=%0d tag=%0d expected count=%0d tag=%0d",
                             got.cnt, got.tag, e.cnt, e.tag);
                end
            end
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL rand_lost: %0d results never emitted", q.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic_lzc();
        test_lo_mode();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
